// File: rtl/cart_bus_pkg.sv
// Shared types and default timing for the cartridge bus sequencer.
package cart_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } cart_state_e;

    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 1;

    // One latched cartridge access: everything the bus needs from SETUP to HOLD exit.
    typedef struct packed {
        logic        wr;
        logic        ram;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cart_req_t;

    // The phase counter counts down to zero, so an N-cycle phase loads N-1.
    function automatic logic [3:0] phase_load(input int cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/cart_bus_seq_if.sv
// Request side (from the mapper) and physical cartridge bus of the sequencer.
interface cart_bus_seq_if;
    logic        req;
    logic        req_wr;
    logic [22:0] req_addr;
    logic        req_ram;
    logic [7:0]  req_wdata;

    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_doe;
    logic [7:0]  bus_din;
    logic        bus_nrd;
    logic        bus_nwr;
    logic        bus_ncs;

    logic [7:0]  rdata;
    logic        rd_valid;
    logic        busy;
    logic        overrun;

    // Master: the mapper issuing requests plus the cartridge returning read data.
    modport master (
        output req, req_wr, req_addr, req_ram, req_wdata, bus_din,
        input  bus_addr, bus_dout, bus_doe, bus_nrd, bus_nwr, bus_ncs,
        input  rdata, rd_valid, busy, overrun
    );

    // Slave: the sequencer itself.
    modport slave (
        input  req, req_wr, req_addr, req_ram, req_wdata, bus_din,
        output bus_addr, bus_dout, bus_doe, bus_nrd, bus_nwr, bus_ncs,
        output rdata, rd_valid, busy, overrun
    );
endinterface

// File: rtl/cart_bus_phase_cnt.sv
// 4-bit loadable down-counter shared by the SETUP, STROBE and HOLD phases.
module cart_bus_phase_cnt (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_tc
);

    logic [3:0] r_cnt;

    // Load wins over decrement; the count parks at zero once reached.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_tc = (r_cnt == 4'd0);

endmodule

// File: rtl/cart_bus_seq.sv
// Cartridge bus sequencer: turns one-cycle mapper requests into timed
// SETUP / STROBE / HOLD bus cycles, with a single-entry pending slot.
module cart_bus_seq
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    cart_bus_seq_if.slave  bus
);

    localparam logic [3:0] LD_SETUP  = phase_load(SETUP_CYC);
    localparam logic [3:0] LD_STROBE = phase_load(STROBE_CYC);
    localparam logic [3:0] LD_HOLD   = phase_load(HOLD_CYC);

    cart_state_e r_state;
    cart_state_e w_state_nxt;

    logic        r_pend_vld;
    cart_req_t   r_pend;
    logic        r_cur_wr;

    logic [15:0] r_addr;
    logic [7:0]  r_dout;
    logic [7:0]  r_rdata;
    logic        r_doe;
    logic        r_nrd;
    logic        r_nwr;
    logic        r_ncs;
    logic        r_rd_valid;
    logic        r_overrun;

    logic        w_tc;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic [3:0]  w_cnt_val;
    logic        w_start_req;
    logic        w_start_pend;
    logic        w_start;
    logic        w_to_strobe;
    logic        w_to_hold;
    logic        w_to_idle;
    logic        w_pend_fill;
    logic        w_drop;
    cart_req_t   w_req;
    cart_req_t   w_new;
    logic        w_unused_addr;

    // Only the low 16 address bits reach the cartridge connector.
    assign w_unused_addr = ^bus.req_addr[22:16];

    assign w_req = '{wr: bus.req_wr, ram: bus.req_ram,
                     addr: bus.req_addr[15:0], wdata: bus.req_wdata};

    cart_bus_phase_cnt u_phase_cnt (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_tc       (w_tc)
    );

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, phase counter control and transaction start selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_val    = 4'd0;
        w_cnt_dec    = 1'b0;
        w_start_req  = 1'b0;
        w_start_pend = 1'b0;
        w_to_strobe  = 1'b0;
        w_to_hold    = 1'b0;
        w_to_idle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_start_req = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tc) begin
                    w_state_nxt = ST_STROBE;
                    w_to_strobe = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = LD_STROBE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                if (w_tc) begin
                    w_state_nxt = ST_HOLD;
                    w_to_hold   = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = LD_HOLD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_tc) begin
                    // A queued request takes precedence; otherwise a request
                    // arriving right now is started without touching the slot.
                    if (r_pend_vld) begin
                        w_start_pend = 1'b1;
                        w_state_nxt  = ST_SETUP;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = LD_SETUP;
                    end else if (bus.req) begin
                        w_start_req = 1'b1;
                        w_state_nxt = ST_SETUP;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = LD_SETUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_to_idle   = 1'b1;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_start     = w_start_req | w_start_pend;
    assign w_new       = w_start_pend ? r_pend : w_req;
    assign w_drop      = bus.req && (r_state != ST_IDLE) && r_pend_vld;
    assign w_pend_fill = bus.req && (r_state != ST_IDLE) && !r_pend_vld && !w_start_req;

    // Pending-slot occupancy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld <= 1'b0;
        end else if (w_pend_fill) begin
            r_pend_vld <= 1'b1;
        end else if (w_start_pend) begin
            r_pend_vld <= 1'b0;
        end
    end

    // Pending-slot payload; only meaningful while r_pend_vld is set.
    always_ff @(posedge clk_sys) begin
        if (w_pend_fill) begin
            r_pend <= w_req;
        end
    end

    // Registered bus pins, read capture and status pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= 16'd0;
            r_dout     <= 8'd0;
            r_doe      <= 1'b0;
            r_ncs      <= 1'b1;
            r_nrd      <= 1'b1;
            r_nwr      <= 1'b1;
            r_cur_wr   <= 1'b0;
            r_rdata    <= 8'd0;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_overrun  <= w_drop;
            if (w_start) begin
                // Address, data, nCS and drive enable are frozen here until HOLD exit.
                r_addr   <= w_new.addr;
                r_dout   <= w_new.wdata;
                r_doe    <= w_new.wr;
                r_ncs    <= ~w_new.ram;
                r_cur_wr <= w_new.wr;
                r_nrd    <= 1'b1;
                r_nwr    <= 1'b1;
            end else if (w_to_strobe) begin
                r_nrd <= r_cur_wr;
                r_nwr <= ~r_cur_wr;
            end else if (w_to_hold) begin
                r_nrd <= 1'b1;
                r_nwr <= 1'b1;
                if (!r_cur_wr) begin
                    r_rdata    <= bus.bus_din;
                    r_rd_valid <= 1'b1;
                end
            end else if (w_to_idle) begin
                r_doe <= 1'b0;
                r_ncs <= 1'b1;
            end
        end
    end

    assign bus.bus_addr = r_addr;
    assign bus.bus_dout = r_dout;
    assign bus.bus_doe  = r_doe;
    assign bus.bus_ncs  = r_ncs;
    assign bus.bus_nrd  = r_nrd;
    assign bus.bus_nwr  = r_nwr;
    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign bus.overrun  = r_overrun;
    assign bus.busy     = (r_state != ST_IDLE) | r_pend_vld;

endmodule

// File: tb/tb_cart_bus_seq.sv
// Bench for cart_bus_seq: random and directed traffic scored against an
// interval-based model of the bus timing, plus a 1/1/1-timing instance.
module tb_cart_bus_seq;

    localparam int S    = 2;
    localparam int ST   = 4;
    localparam int H    = 1;
    localparam int D    = S + ST + H;
    localparam int MAXC = 4096;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_err   = 0;

    cart_bus_seq_if mi();
    cart_bus_seq_if fi();

    cart_bus_seq #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) u_dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (mi)
    );

    cart_bus_seq #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (fi)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Cartridge: drives a value derived from the address only while nRD is low.
    function automatic logic [7:0] cart(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC7;
    endfunction

    assign mi.bus_din = mi.bus_nrd ? 8'h00 : cart(mi.bus_addr);
    assign fi.bus_din = fi.bus_nrd ? 8'h00 : cart(fi.bus_addr);

    // Expected per-cycle bus picture and event queues.
    bit          e_busy [MAXC];
    bit          e_act  [MAXC];
    bit          e_nrd  [MAXC];
    bit          e_nwr  [MAXC];
    bit          e_ncs  [MAXC];
    bit          e_doe  [MAXC];
    logic [15:0] e_addr [MAXC];
    logic [7:0]  e_dout [MAXC];

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    ev_t        rd_q[$];
    int         ov_q[$];
    int         last_s;
    bit         have_txn;
    logic [7:0] last_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear(input int from);
        for (int k = from; k < MAXC; k++) begin
            e_busy[k] = 1'b0; e_act[k] = 1'b0; e_nrd[k] = 1'b1; e_nwr[k] = 1'b1;
            e_ncs[k]  = 1'b1; e_doe[k] = 1'b0; e_addr[k] = 16'd0; e_dout[k] = 8'd0;
        end
    endtask

    task automatic model_reset(input int from);
        model_clear(from);
        rd_q.delete();
        ov_q.delete();
        have_txn   = 1'b0;
        last_s     = 0;
        last_rdata = 8'd0;
    endtask

    // Schedule a request seen in cycle c. Each accepted transaction occupies
    // cycles s..s+D-1; the machine is idle once the last one has finished, and
    // the slot is occupied while the last scheduled start still lies ahead.
    task automatic model_req(input int c, input bit wr, input logic [15:0] a,
                             input bit ram, input logic [7:0] wd);
        int s;
        if (!have_txn || c >= last_s + D) begin
            s = c + 1;
        end else if (last_s >= c + 1) begin
            ov_q.push_back(c + 1);
            return;
        end else begin
            s = last_s + D;
        end
        if (s + D >= MAXC) return;
        for (int k = c + 1; k < s + D; k++) e_busy[k] = 1'b1;
        for (int k = s; k < s + D; k++) begin
            e_act[k] = 1'b1; e_addr[k] = a; e_ncs[k] = ~ram;
            e_doe[k] = wr;   e_dout[k] = wd;
        end
        for (int k = s + S; k < s + S + ST; k++) begin
            if (wr) e_nwr[k] = 1'b0;
            else    e_nrd[k] = 1'b0;
        end
        if (!wr) rd_q.push_back('{cyc: s + S + ST, d: cart(a)});
        last_s   = s;
        have_txn = 1'b1;
    endtask

    task automatic step(input bit r, input bit wr, input logic [22:0] a,
                        input bit ram, input logic [7:0] wd);
        @(posedge clk_sys);
        #1;
        mi.req = r; mi.req_wr = wr; mi.req_addr = a; mi.req_ram = ram; mi.req_wdata = wd;
        if (r) model_req(cyc, wr, a[15:0], ram, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 23'd0, 1'b0, 8'd0);
    endtask

    task automatic reset_abort(input bit wr);
        step(1'b1, wr, 23'h003333, 1'b1, 8'hAA);
        idle(3);
        #2;
        reset_n = 1'b0;
        model_reset(cyc);
        #1;
        chk("abort_nrd", 32'(mi.bus_nrd), 32'd1);
        chk("abort_nwr", 32'(mi.bus_nwr), 32'd1);
        chk("abort_ncs", 32'(mi.bus_ncs), 32'd1);
        chk("abort_doe", 32'(mi.bus_doe), 32'd0);
        chk("abort_busy", 32'(mi.busy), 32'd0);
        chk("abort_rd_valid", 32'(mi.rd_valid), 32'd0);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 23'h005A5A, 1'b0, 8'd0);
        idle(12);
    endtask

    task automatic fast_read(input logic [15:0] a);
        @(posedge clk_sys);
        #1;
        fi.req = 1'b1; fi.req_wr = 1'b0; fi.req_addr = {7'd0, a}; fi.req_ram = 1'b0; fi.req_wdata = 8'd0;
        @(posedge clk_sys);
        #1;
        fi.req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_sys);
            chk("fast_rd_valid", 32'(fi.rd_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("fast_rdata", 32'(fi.rdata), 32'(cart(a)));
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic fast_wr_rd();
        @(posedge clk_sys);
        #1;
        fi.req = 1'b1; fi.req_wr = 1'b1; fi.req_addr = 23'h000010; fi.req_wdata = 8'h11;
        @(posedge clk_sys);
        #1;
        fi.req_wr = 1'b0; fi.req_addr = 23'h000020; fi.req_wdata = 8'h00;
        @(posedge clk_sys);
        #1;
        fi.req = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk_sys);
            if (k == 2) chk("fast_dout", 32'(fi.bus_dout), 32'h11);
            chk("fast_wr_rd_valid", 32'(fi.rd_valid), (k == 6) ? 32'd1 : 32'd0);
        end
        chk("fast_wr_rdata", 32'(fi.rdata), 32'(cart(16'h0020)));
        chk("fast_busy_end", 32'(fi.busy), 32'd0);
    endtask

    // Monitor: compares the DUT against the model every cycle on the falling edge.
    always @(negedge clk_sys) begin
        bit rd_exp;
        bit ov_exp;
        if (cyc < MAXC) begin
            chk("busy", 32'(mi.busy), 32'(e_busy[cyc]));
            chk("bus_nrd", 32'(mi.bus_nrd), 32'(e_nrd[cyc]));
            chk("bus_nwr", 32'(mi.bus_nwr), 32'(e_nwr[cyc]));
            chk("bus_ncs", 32'(mi.bus_ncs), 32'(e_ncs[cyc]));
            chk("bus_doe", 32'(mi.bus_doe), 32'(e_doe[cyc]));
            if (e_act[cyc]) chk("bus_addr", 32'(mi.bus_addr), 32'(e_addr[cyc]));
            if (e_act[cyc] && e_doe[cyc]) chk("bus_dout", 32'(mi.bus_dout), 32'(e_dout[cyc]));
        end
        chk("strobe_excl", 32'(!mi.bus_nrd && !mi.bus_nwr), 32'd0);
        chk("doe_during_rd", 32'(!mi.bus_nrd && mi.bus_doe), 32'd0);

        rd_exp = (rd_q.size() != 0) && (rd_q[0].cyc == cyc);
        chk("rd_valid", 32'(mi.rd_valid), 32'(rd_exp));
        if (rd_exp) begin
            chk("rdata_capture", 32'(mi.rdata), 32'(rd_q[0].d));
            last_rdata = rd_q[0].d;
            void'(rd_q.pop_front());
        end else begin
            chk("rdata_hold", 32'(mi.rdata), 32'(last_rdata));
        end

        ov_exp = (ov_q.size() != 0) && (ov_q[0] == cyc);
        chk("overrun", 32'(mi.overrun), 32'(ov_exp));
        if (ov_exp) void'(ov_q.pop_front());

        chk("fast_strobe_excl", 32'(!fi.bus_nrd && !fi.bus_nwr), 32'd0);
        chk("fast_doe_during_rd", 32'(!fi.bus_nrd && fi.bus_doe), 32'd0);
        chk("fast_ncs", 32'(fi.bus_ncs), 32'd1);
        chk("fast_overrun", 32'(fi.overrun), 32'd0);
    end

    initial begin
        mi.req = 1'b0; mi.req_wr = 1'b0; mi.req_addr = 23'd0; mi.req_ram = 1'b0; mi.req_wdata = 8'd0;
        fi.req = 1'b0; fi.req_wr = 1'b0; fi.req_addr = 23'd0; fi.req_ram = 1'b0; fi.req_wdata = 8'd0;
        model_reset(0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_nrd", 32'(mi.bus_nrd), 32'd1);
        chk("rst_nwr", 32'(mi.bus_nwr), 32'd1);
        chk("rst_ncs", 32'(mi.bus_ncs), 32'd1);
        chk("rst_doe", 32'(mi.bus_doe), 32'd0);
        chk("rst_addr", 32'(mi.bus_addr), 32'd0);
        chk("rst_dout", 32'(mi.bus_dout), 32'd0);
        chk("rst_rdata", 32'(mi.rdata), 32'd0);
        chk("rst_rd_valid", 32'(mi.rd_valid), 32'd0);
        chk("rst_busy", 32'(mi.busy), 32'd0);
        chk("rst_overrun", 32'(mi.overrun), 32'd0);
        repeat (2) @(posedge clk_sys);
        #2;
        reset_n = 1'b1;

        // Single read of 0x4123 (cartridge returns 0xA5), then a RAM write.
        step(1'b1, 1'b0, 23'h004123, 1'b0, 8'h00);
        idle(9);
        step(1'b1, 1'b1, 23'h002000, 1'b1, 8'h5C);
        idle(9);

        // Three back-to-back requests: the third finds the slot full.
        step(1'b1, 1'b0, 23'h000100, 1'b0, 8'h00);
        step(1'b1, 1'b1, 23'h000200, 1'b1, 8'h77);
        step(1'b1, 1'b0, 23'h000300, 1'b0, 8'h00);
        idle(16);

        // Request arriving in the HOLD-exit cycle of the previous read.
        step(1'b1, 1'b0, 23'h001111, 1'b0, 8'h00);
        idle(6);
        step(1'b1, 1'b0, 23'h002222, 1'b1, 8'h00);
        idle(12);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, 1'($urandom), 23'($urandom),
                 1'($urandom), 8'($urandom));
        end
        idle(24);

        // Mid-transaction resets during STROBE, write then read.
        reset_abort(1'b1);
        reset_abort(1'b0);

        // Minimum timing instance.
        fast_read(16'h4123);
        fast_read(16'h0F0F);
        fast_wr_rd();
        idle(4);

        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("ov_queue_drained", 32'(ov_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
